// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the packet type for the fetch stage.
//   INSTR_W     - instruction word width
//   PC_STEP     - byte distance between sequential instruction words
//   fetch_pkt_t - {pc, instr} pair handed from the fetch stage to decode
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam int PKT_PC_W = 32;

    typedef struct packed {
        logic [PKT_PC_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: two-entry output stage (output register + skid register).
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset (clears valids and packets)
//   flush       - drop both entries this cycle (highest priority after rst)
//   in_valid    - a packet arrives this cycle; the producer only offers one when
//                 skid_valid is 0, so no input ready is needed
//   in_pkt      - arriving packet
//   out_valid   - output register holds a packet
//   out_ready   - consumer accepts out_pkt this cycle
//   out_pkt     - packet presented to the consumer
//   skid_valid  - second entry occupied; the producer must not offer more
//
// Handshake: a transfer happens on a posedge where out_valid && out_ready are both
// high; while out_valid && !out_ready, out_pkt and out_valid do not change.
import fetch_pkg::*;

module fetch_skid_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  fetch_pkt_t in_pkt,
    output logic       out_valid,
    input  logic       out_ready,
    output fetch_pkt_t out_pkt,
    output logic       skid_valid
);

    fetch_pkt_t skid_pkt;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            skid_valid <= 1'b0;
            skid_pkt   <= '0;
        end else if (flush) begin
            // Only the valids are dropped; stale payloads are never observed.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_valid && out_ready && skid_valid) begin
            // Pop: the skid entry is older than anything that could arrive, and
            // the producer is gated off while skid_valid is set.
            out_pkt    <= skid_pkt;
            skid_valid <= 1'b0;
        end else if (in_valid) begin
            if (!out_valid || out_ready) begin
                out_pkt   <= in_pkt;
                out_valid <= 1'b1;
            end else begin
                skid_pkt   <= in_pkt;
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a synchronous instruction memory.
// Owns the PC, drives the word address, re-pairs the one-cycle-late read data
// with its PC and presents {out_pc, out_instr} to decode.
//
// Parameters:
//   ADDR_W    - PC / address width (at most 32)
//   RESET_PC  - first fetch address after reset
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   redirect_valid, redirect_pc - taken branch/jump; flushes everything in flight,
//                                 target low two bits are forced to zero
//   imem_addr                   - byte address to memory, always the pc register
//   imem_instr                  - memory data for the address of the previous cycle
//   out_valid, out_ready        - decode handshake; transfer when both are high
//   out_pc, out_instr           - fetched instruction and its byte address
//   fetch_count, stall_count    - only with FETCH_PERF_EN defined: output transfers
//                                 and cycles with no issue (outside rst/redirect)
//
// Build option: FETCH_PERF_EN adds the two performance counters.
import fetch_pkg::*;

module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              skid_valid;
    fetch_pkt_t        land_pkt;
    fetch_pkt_t        out_pkt;

    // A new fetch is only started when its data is guaranteed a slot one cycle
    // later: the skid must be empty, and a fetch already landing must not be the
    // one that fills the skid behind a stalled output.
    always_comb begin
        issue = !rst && !redirect_valid && !skid_valid
                && !(inflight && out_valid && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~ADDR_W'(3);
            inflight <= 1'b0;
        end else if (issue) begin
            pc          <= pc + ADDR_W'(PC_STEP);
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    assign imem_addr = pc;

    always_comb begin
        land_pkt       = '0;
        land_pkt.pc    = PKT_PC_W'(inflight_pc);
        land_pkt.instr = imem_instr;
    end

    fetch_skid_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .in_valid   (inflight),
        .in_pkt     (land_pkt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pkt    (out_pkt),
        .skid_valid (skid_valid)
    );

    assign out_pc    = ADDR_W'(out_pkt.pc);
    assign out_instr = out_pkt.instr;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            // A transfer in a redirect cycle is still accepted by decode.
            if (out_valid && out_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (!issue && !redirect_valid) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a sequential-stream model.
// The model expects out_pc to walk 4 bytes at a time from the last reset or
// redirect target, with out_instr equal to the memory word at that address, and
// checks every transfer plus output stability under back-pressure. Directed steps
// pin exact cycle timing with hand-computed literals.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    // Memory content: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Synchronous memory: data for the address presented in cycle N shows up in N+1.
    always @(posedge clk) imem_instr <= word_of(imem_addr);

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    function automatic void refill(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(base + 32'(4 * i));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            refill(RESET_PC);
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_pc", out_pc, prev_pc);
                check("hold_instr", out_instr, prev_instr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", out_pc, 32'hffff_ffff);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("xfer_pc", out_pc, e);
                    check("xfer_instr", out_instr, word_of(e));
                end
            end
            if (redirect_valid) refill({redirect_pc[31:2], 2'b00});
            hold_prev  = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Returns at the negedge where out_pc == pc is presented, or after a budget.
    task automatic wait_out(input logic [31:0] pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_pc === pc) found = 1'b1;
        end
        check("wait_reach", {31'b0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [23:0] pat;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        at_neg();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);

        // First low cycle C
        tick(); rst = 1'b0;
        at_neg();
        check("c0_valid", {31'b0, out_valid}, 32'd0);
        check("c0_addr", imem_addr, 32'h0);
        tick(); at_neg();
        check("c1_valid", {31'b0, out_valid}, 32'd0);
        check("c1_addr", imem_addr, 32'h4);
        tick(); at_neg();
        check("c2_valid", {31'b0, out_valid}, 32'd1);
        check("c2_pc", out_pc, 32'h0);
        check("c2_instr", out_instr, 32'h1000_0000);
        tick(); at_neg();
        check("c3_pc", out_pc, 32'h4);

        // Back-pressure for 5 cycles with 0x8 on the output
        tick(); out_ready = 1'b0;
        at_neg();
        check("bp_pc", out_pc, 32'h8);
        check("bp_addr", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            tick(); at_neg();
            check("bp_hold_pc", out_pc, 32'h8);
            check("bp_hold_addr", imem_addr, 32'h10);
        end
        tick(); out_ready = 1'b1;
        at_neg();
        check("rel_pc8", out_pc, 32'h8);
        tick(); at_neg();
        check("rel_pcc", out_pc, 32'hc);
        tick(); at_neg();
        check("rel_bubble", {31'b0, out_valid}, 32'd0);
        tick(); at_neg();
        check("rel_pc10_v", {31'b0, out_valid}, 32'd1);
        check("rel_pc10", out_pc, 32'h10);

        // Redirect while the skid is full and the output is stalled
        wait_out(32'h18);
        tick(); out_ready = 1'b0;
        at_neg();
        check("r1_pre_pc", out_pc, 32'h1c);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h43;
        at_neg();
        check("r1_addr_frozen", imem_addr, 32'h24);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        at_neg();
        check("r1_n1_valid", {31'b0, out_valid}, 32'd0);
        check("r1_n1_addr", imem_addr, 32'h40);
        tick(); at_neg();
        check("r1_n2_valid", {31'b0, out_valid}, 32'd0);
        tick(); at_neg();
        check("r1_n3_valid", {31'b0, out_valid}, 32'd1);
        check("r1_n3_pc", out_pc, 32'h40);
        check("r1_n3_instr", out_instr, 32'h1000_0010);

        // Redirect in the same cycle as a transfer
        wait_out(32'h48);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        at_neg();
        check("r2_xfer_pc", out_pc, 32'h4c);
        tick(); redirect_valid = 1'b0;
        at_neg();
        check("r2_n1_valid", {31'b0, out_valid}, 32'd0);
        tick(); at_neg();
        check("r2_n2_valid", {31'b0, out_valid}, 32'd0);
        tick(); at_neg();
        check("r2_n3_pc", out_pc, 32'h100);

        // Irregular back-pressure; the scoreboard checks order and stability
        pat = 24'b1011_0011_1000_1101_0110_0111;
        for (int i = 0; i < 24; i++) begin
            tick(); out_ready = pat[i];
        end
        tick(); out_ready = 1'b1;

        // Address wrap at the top of the space
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hffff_fff9;
        tick(); redirect_valid = 1'b0;
        wait_out(32'hffff_fffc);
        tick(); at_neg();
        check("wrap_pc", out_pc, 32'h0);
        check("wrap_instr", out_instr, 32'h1000_0000);

        // Reset mid-stream, then the counter scenario from the new C
        wait_out(32'h8);
        tick(); rst = 1'b1;
        at_neg();
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        tick(); rst = 1'b0;
        at_neg();
        check("mrst_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_pc", out_pc, 32'h0);
        check("mrst_instr", out_instr, 32'h0);
        check("mrst_addr", imem_addr, RESET_PC);
        repeat (3) tick();              // C+3
        tick(); out_ready = 1'b0;       // C+4
        tick();                         // C+5
        tick(); out_ready = 1'b1;       // C+6
        tick(); tick();                 // C+8
        at_neg();
        check("perf_bubble", {31'b0, out_valid}, 32'd0);
        repeat (7) tick();              // C+15
        at_neg();
        check("perf_pc", out_pc, 32'h28);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, 32'd10);
        check("stall_count", stall_count, 32'd3);
`endif
        repeat (3) tick();

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
